// File: rtl/pd_readout.sv
// Readout end of the peak detector: pops valid peaks into a local FIFO and frames each one as an A5-led byte stream.
// Optional build macro PD_TIMESTAMP_EN appends a free-running capture timestamp to every frame.
module pd_readout #(
    parameter int WD    = 24,
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [WD-1:0]     peak_in,
    input  logic                     valid_in,
    output logic                     read_shift,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              stall_cnt
);

`ifdef PD_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    localparam int AW  = $clog2(DEPTH);
    localparam int FW  = WD + (TS_EN ? TS_W : 0);
    localparam int NB  = FW / 8;
    localparam int BCW = $clog2(NB + 1);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

    logic [FW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push;
    logic           pop;
    logic [FW-1:0]  push_word;

    state_t         state;
    state_t         state_nxt;
    logic [FW-1:0]  shreg;
    logic [FW-1:0]  shreg_nxt;
    logic [BCW-1:0] bleft;
    logic [BCW-1:0] bleft_nxt;
    logic [7:0]     out_data_nxt;
    logic           out_valid_nxt;
    logic           hs;

    // Full flag only: a same-cycle pop never frees a slot for the push.
    assign read_shift = !rst && (level != FULL_LVL);
    assign push       = read_shift && valid_in;
    assign hs         = out_valid && out_ready;

`ifdef PD_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clk) begin
        if (rst) ts <= '0;
        else     ts <= ts + TS_W'(1);
    end

    assign push_word = {peak_in, ts};
`else
    assign push_word = peak_in;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                           stall_cnt <= '0;
        else if (valid_in && !read_shift && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bleft_nxt     = bleft;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop           = 1'b1;
                    shreg_nxt     = mem[rd_ptr];
                    out_data_nxt  = 8'hA5;
                    out_valid_nxt = 1'b1;
                    state_nxt     = SYNC;
                end
            end
            SYNC: begin
                if (hs) begin
                    out_data_nxt = shreg[FW-1 -: 8];
                    shreg_nxt    = shreg << 8;
                    bleft_nxt    = BCW'(NB - 1);
                    state_nxt    = DATA;
                end
            end
            DATA: begin
                if (hs) begin
                    if (bleft == '0) begin
                        out_valid_nxt = 1'b0;
                        state_nxt     = IDLE;
                    end else begin
                        out_data_nxt = shreg[FW-1 -: 8];
                        shreg_nxt    = shreg << 8;
                        bleft_nxt    = bleft - BCW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            bleft     <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            bleft     <= bleft_nxt;
        end
    end

    // Frame shift register carries data only; the FSM decides when it is meaningful.
    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
    end

endmodule

// File: tb/tb_pd_readout.sv
// Bench for pd_readout: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_pd_readout;

    localparam int WD    = 24;
    localparam int DEPTH = 8;
    localparam int TS_W  = 16;
`ifdef PD_TIMESTAMP_EN
    localparam int FW = WD + TS_W;
`else
    localparam int FW = WD;
`endif
    localparam int NBYTES = 1 + FW / 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [WD-1:0] peak_in = '0;
    logic                 valid_in = 1'b0;
    logic                 read_shift;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [3:0]           level;
    logic [15:0]          stall_cnt;

    int tests = 0;
    int fails = 0;

    pd_readout #(.WD(WD), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .rst(rst), .peak_in(peak_in), .valid_in(valid_in),
        .read_shift(read_shift), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: captured words as a queue, expected byte stream as a queue.
    logic [FW-1:0]   mq[$];
    logic [7:0]      eb[$];
    int              left = 0;
    int              stall_m = 0;
    logic [15:0]     ts_m = '0;
    logic [FW-1:0]   w;
    bit              m_rs;
    bit              m_pop;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            eb.delete();
            left    = 0;
            stall_m = 0;
            ts_m    = '0;
        end else begin
            m_rs  = (mq.size() != DEPTH);
            m_pop = (left == 0) && (mq.size() > 0);
            if (left > 0 && out_ready) begin
                if (eb.size() > 0) void'(eb.pop_front());
                left--;
            end
            if (m_pop) begin
                void'(mq.pop_front());
                left = NBYTES;
            end
            if (valid_in && m_rs) begin
`ifdef PD_TIMESTAMP_EN
                w = {peak_in, ts_m};
`else
                w = peak_in;
`endif
                mq.push_back(w);
                eb.push_back(8'hA5);
                for (int i = 0; i < FW / 8; i++) eb.push_back(w[FW-1-8*i -: 8]);
            end
            if (valid_in && !m_rs && stall_m < 65535) stall_m++;
            ts_m = ts_m + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("read_shift_in_reset", 64'(read_shift), 64'(0));
        end else begin
            chk("level", 64'(level), 64'(mq.size()));
            chk("read_shift", 64'(read_shift), 64'(mq.size() != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(left > 0));
            chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
            if (out_valid) begin
                if (eb.size() == 0) chk("out_data_unexpected", 64'(1), 64'(0));
                else                chk("out_data", 64'(out_data), 64'(eb[0]));
            end
        end
    end

    logic [7:0] cb [16];
    int         cgot;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic collect(input int n, input bit cur);
        cgot = 0;
        for (int k = 0; k < 200 && cgot < n; k++) begin
            if (!(cur && k == 0)) @(negedge clk);
            if (out_valid && out_ready) begin
                cb[cgot] = out_data;
                cgot++;
            end
        end
        chk("collect_count", 64'(cgot), 64'(n));
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (!out_valid && level == 4'd0 && eb.size() == 0) ok = 1'b1;
        end
        chk("idle_reached", 64'(ok), 64'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [WD-1:0] peak;
        logic [31:0]   exp;
    } vec_t;

    vec_t        vt [4];
    logic [15:0] cap_ts;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{peak: 24'h0001F4, exp: 32'hA50001F4};
        vt[1] = '{peak: 24'hFFFE0C, exp: 32'hA5FFFE0C};
        vt[2] = '{peak: 24'h800000, exp: 32'hA5800000};
        vt[3] = '{peak: 24'h7FFFFF, exp: 32'hA57FFFFF};

        // Reset values
        rst = 1'b1;
        step(2);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_stall", 64'(stall_cnt), 64'(0));
        chk("rst_read_shift", 64'(read_shift), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("read_shift_after_rst", 64'(read_shift), 64'(1));

        // Single-peak frames from the vector table
        for (int v = 0; v < 4; v++) begin
            step(1);
            out_ready = 1'b1;
            peak_in   = vt[v].peak;
            valid_in  = 1'b1;
            cap_ts    = ts_m;
            step(1);
            valid_in = 1'b0;
            @(negedge clk);
            chk("vec_level_after_capture", 64'(level), 64'(1));
            chk("vec_no_early_valid", 64'(out_valid), 64'(0));
            @(negedge clk);
            chk("vec_sync_valid", 64'(out_valid), 64'(1));
            chk("vec_sync_byte", 64'(out_data), 64'(8'hA5));
            chk("vec_level_after_pop", 64'(level), 64'(0));
            collect(NBYTES, 1'b1);
            chk("vec_bytes", 64'({cb[0], cb[1], cb[2], cb[3]}), 64'(vt[v].exp));
`ifdef PD_TIMESTAMP_EN
            chk("vec_ts", 64'({cb[4], cb[5]}), 64'(cap_ts));
`endif
            wait_idle();
        end

        // Backpressure for 10 cycles after the second payload byte is shown
        step(1);
        out_ready = 1'b1;
        peak_in   = 24'h123456;
        valid_in  = 1'b1;
        step(1);
        valid_in = 1'b0;
        collect(3, 1'b0);
        out_ready = 1'b0;
        chk("bp_head", 64'({cb[0], cb[1], cb[2]}), 64'(24'hA51234));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_data", 64'(out_data), 64'(8'h34));
            chk("bp_hold_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        collect(NBYTES - 3, 1'b0);
        chk("bp_tail", 64'(cb[0]), 64'(8'h56));
        wait_idle();

        // Full FIFO: one word leaves for the serializer, so ten pushes stall once
        step(1);
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            peak_in  = WD'(32'h100 + i);
            valid_in = 1'b1;
            step(1);
        end
        valid_in = 1'b0;
        @(negedge clk);
        chk("full_level", 64'(level), 64'(8));
        chk("full_read_shift", 64'(read_shift), 64'(0));
        chk("full_stall", 64'(stall_cnt), 64'(1));
        out_ready = 1'b1;
        wait_idle();

        // Mid-frame reset with one word still queued
        step(1);
        peak_in  = 24'hABCDEF;
        valid_in = 1'b1;
        step(1);
        peak_in = 24'h13579B;
        step(1);
        valid_in = 1'b0;
        collect(2, 1'b0);
        chk("mid_bytes", 64'({cb[0], cb[1]}), 64'(16'hA5AB));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_out_valid", 64'(out_valid), 64'(0));
        chk("mid_level", 64'(level), 64'(0));
        chk("mid_stall", 64'(stall_cnt), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("mid_read_shift", 64'(read_shift), 64'(1));

        // Random traffic
        step(1);
        for (int i = 0; i < 3000; i++) begin
            valid_in  = ($urandom_range(0, 99) < 40);
            peak_in   = WD'($urandom);
            out_ready = ($urandom_range(0, 99) < 60);
            step(1);
        end
        valid_in  = 1'b0;
        out_ready = 1'b1;
        wait_idle();

`ifdef PD_TIMESTAMP_EN
        // Capture stamped 0x0123 after reset
        step(1);
        do_reset();
        for (int k = 0; k < 1000 && ts_m != 16'h0123; k++) step(1);
        chk("ts_reach_0123", 64'(ts_m), 64'(16'h0123));
        peak_in  = 24'h000200;
        valid_in = 1'b1;
        step(1);
        valid_in = 1'b0;
        collect(6, 1'b0);
        chk("ts_frame", 64'({cb[0], cb[1], cb[2], cb[3], cb[4], cb[5]}), 64'(48'hA50002000123));
        wait_idle();

        // Counter wrap across two consecutive captures
        for (int k = 0; k < 70000 && ts_m != 16'hFFFF; k++) step(1);
        chk("ts_reach_ffff", 64'(ts_m), 64'(16'hFFFF));
        peak_in  = 24'h000001;
        valid_in = 1'b1;
        step(1);
        peak_in = 24'h000002;
        step(1);
        valid_in = 1'b0;
        collect(12, 1'b0);
        chk("ts_wrap_a", 64'({cb[3], cb[4], cb[5]}), 64'(24'h01FFFF));
        chk("ts_wrap_b", 64'({cb[9], cb[10], cb[11]}), 64'(24'h020000));
        wait_idle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
